// File: rtl/fetch_pkg.sv
// Shared types for the fetch line sequencer: FSM states, redirect priorities
// and the line-address width helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fetch_state_e;

  // Numeric order is the arbitration order, so plain >= compares priority.
  typedef enum logic [1:0] {
    PRIO_NONE    = 2'd0,
    PRIO_BP      = 2'd1,
    PRIO_RESTEER = 2'd2,
    PRIO_INIT    = 2'd3
  } redir_prio_e;

  function automatic int line_addr_w(input int addr_w, input int line_bytes);
    return addr_w - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/fetch_bank_ptr.sv
// One interleaved I$ bank's line pointer: loads from a redirect line, steps by
// NBANKS when the bank consumes its line, otherwise holds.
module fetch_bank_ptr #(
  parameter int NBANKS   = 2,
  parameter int LA_W     = 28,
  parameter int BANK_IDX = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic [LA_W-1:0] redir_line_i,
  input  logic            adv_i,
  output logic [LA_W-1:0] line_o,
  output logic            valid_o
);

  localparam int BANK_W = $clog2(NBANKS);
  localparam logic [BANK_W-1:0] MY_IDX = BANK_W'(BANK_IDX);

  logic [BANK_W-1:0] off;
  logic [LA_W-1:0]   line_d, line_q;
  logic              valid_d, valid_q;

  // Smallest line >= the redirect line that maps onto this bank.
  assign off = MY_IDX - redir_line_i[BANK_W-1:0];

  always_comb begin
    line_d  = line_q;
    valid_d = valid_q;
    if (load_i) begin
      line_d  = redir_line_i + LA_W'(off);
      valid_d = 1'b1;
    end else if (adv_i) begin
      line_d = line_q + LA_W'(NBANKS);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      line_q  <= line_d;
      valid_q <= valid_d;
    end
  end

  assign line_o  = line_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_line_seq.sv
// Fetch line sequencer: arbitrates redirects, parks one during fetch_hold and
// steps the per-bank line pointers as banks consume lines.
module fetch_line_seq
  import fetch_pkg::*;
#(
  parameter int NBANKS     = 2,
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int EPOCH_W    = 3
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             init_valid,
  input  logic [ADDR_W-1:0]                                init_addr,
  input  logic                                             resteer_valid,
  input  logic [ADDR_W-1:0]                                resteer_addr,
  input  logic                                             bp_valid,
  input  logic [ADDR_W-1:0]                                bp_addr,
  input  logic                                             fetch_hold,
  input  logic [NBANKS-1:0]                                bank_ld,
  output logic [NBANKS*line_addr_w(ADDR_W, LINE_BYTES)-1:0] bank_line,
  output logic [NBANKS-1:0]                                bank_valid,
  output logic [$clog2(NBANKS)-1:0]                        head_bank,
  output logic [EPOCH_W-1:0]                               epoch,
  output logic                                             redirect_pending
);

  localparam int LA_W   = line_addr_w(ADDR_W, LINE_BYTES);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BANK_W = $clog2(NBANKS);

  fetch_state_e        state_d, state_q;
  redir_prio_e         new_prio, pend_prio_d, pend_prio_q;
  logic [LA_W-1:0]     new_line, pend_line_d, pend_line_q, apply_line;
  logic                apply, adv, pend_q;
  logic [NBANKS-1:0]   adv_b;
  logic [BANK_W:0]     run_k;
  logic                contig;
  logic [BANK_W-1:0]   head_d, head_q;
  logic [EPOCH_W-1:0]  epoch_d, epoch_q;

  // Byte offsets within a line never affect which line is fetched.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{init_addr[OFF_W-1:0], resteer_addr[OFF_W-1:0],
                              bp_addr[OFF_W-1:0]};

  // IDLE only listens to init; elsewhere init > resteer > bp.
  always_comb begin
    new_prio = PRIO_NONE;
    new_line = '0;
    if (init_valid) begin
      new_prio = PRIO_INIT;
      new_line = init_addr[ADDR_W-1:OFF_W];
    end else if (resteer_valid && state_q != ST_IDLE) begin
      new_prio = PRIO_RESTEER;
      new_line = resteer_addr[ADDR_W-1:OFF_W];
    end else if (bp_valid && state_q != ST_IDLE) begin
      new_prio = PRIO_BP;
      new_line = bp_addr[ADDR_W-1:OFF_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_line_d = pend_line_q;
    pend_prio_d = pend_prio_q;
    apply       = 1'b0;
    apply_line  = new_line;
    adv         = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (new_prio != PRIO_NONE) begin
          if (fetch_hold) begin
            pend_line_d = new_line;
            pend_prio_d = new_prio;
            state_d     = ST_PEND;
          end else begin
            apply   = 1'b1;
            state_d = ST_RUN;
          end
        end else if (state_q == ST_RUN && !fetch_hold) begin
          adv = 1'b1;
        end
      end
      ST_PEND: begin
        if (fetch_hold) begin
          if (new_prio != PRIO_NONE && new_prio >= pend_prio_q) begin
            pend_line_d = new_line;
            pend_prio_d = new_prio;
          end
        end else begin
          apply       = 1'b1;
          state_d     = ST_RUN;
          pend_prio_d = PRIO_NONE;
          if (!(new_prio != PRIO_NONE && new_prio >= pend_prio_q)) begin
            apply_line = pend_line_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Count of consecutive consuming banks starting at the head, wrapping.
  always_comb begin
    run_k  = '0;
    contig = 1'b1;
    for (int i = 0; i < NBANKS; i++) begin
      if (contig && bank_ld[head_q + BANK_W'(i)]) begin
        run_k = run_k + 1'b1;
      end else begin
        contig = 1'b0;
      end
    end
  end

  assign adv_b = {NBANKS{adv}} & bank_ld;

  always_comb begin
    head_d  = head_q;
    epoch_d = epoch_q;
    if (apply) begin
      head_d  = apply_line[BANK_W-1:0];
      epoch_d = epoch_q + 1'b1;
    end else if (adv) begin
      head_d = head_q + run_k[BANK_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_line_q <= '0;
      pend_prio_q <= PRIO_NONE;
      pend_q      <= 1'b0;
      head_q      <= '0;
      epoch_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_line_q <= pend_line_d;
      pend_prio_q <= pend_prio_d;
      pend_q      <= (state_d == ST_PEND);
      head_q      <= head_d;
      epoch_q     <= epoch_d;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    fetch_bank_ptr #(
      .NBANKS  (NBANKS),
      .LA_W    (LA_W),
      .BANK_IDX(b)
    ) u_ptr (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (apply),
      .redir_line_i(apply_line),
      .adv_i       (adv_b[b]),
      .line_o      (bank_line[b*LA_W +: LA_W]),
      .valid_o     (bank_valid[b])
    );
  end

  assign head_bank        = head_q;
  assign epoch            = epoch_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_fetch_line_seq.sv
// Bench for fetch_line_seq: directed vectors, an arithmetic model compared
// every cycle, and literal expectations at key points.
module tb_fetch_line_seq;

  localparam int N  = 2;
  localparam int LA = 28;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          init_valid, resteer_valid, bp_valid, fetch_hold;
  logic [31:0]   init_addr, resteer_addr, bp_addr;
  logic [N-1:0]  bank_ld;
  logic [N*LA-1:0] bank_line;
  logic [N-1:0]  bank_valid;
  logic          head_bank;
  logic [2:0]    epoch;
  logic          redirect_pending;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_line_seq dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .init_valid      (init_valid),
    .init_addr       (init_addr),
    .resteer_valid   (resteer_valid),
    .resteer_addr    (resteer_addr),
    .bp_valid        (bp_valid),
    .bp_addr         (bp_addr),
    .fetch_hold      (fetch_hold),
    .bank_ld         (bank_ld),
    .bank_line       (bank_line),
    .bank_valid      (bank_valid),
    .head_bank       (head_bank),
    .epoch           (epoch),
    .redirect_pending(redirect_pending)
  );

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [LA-1:0] line_of(input int b);
    return bank_line[b*LA +: LA];
  endfunction

  // ---------------- behavioural model ----------------
  logic [LA-1:0] m_line [N];
  logic [N-1:0]  m_valid;
  int            m_head, m_epoch, m_prank;
  bit            m_run, m_pend;
  logic [31:0]   m_paddr;

  function automatic void m_apply(input logic [31:0] a);
    longint l;
    int off;
    l = longint'(a >> 4);
    for (int b = 0; b < N; b++) begin
      off = ((b - int'(l % N)) % N + N) % N;
      m_line[b] = LA'(l + off);
    end
    m_valid = '1;
    m_head  = int'(l % N);
    m_epoch = (m_epoch + 1) % 8;
    m_run   = 1'b1;
    m_pend  = 1'b0;
    m_prank = 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int nr, k;
    logic [31:0] na;
    if (!reset_n) begin
      for (int b = 0; b < N; b++) m_line[b] = '0;
      m_valid = '0; m_head = 0; m_epoch = 0; m_prank = 0;
      m_run = 1'b0; m_pend = 1'b0; m_paddr = '0;
    end else begin
      nr = 0; na = '0;
      if (init_valid) begin nr = 3; na = init_addr; end
      else if ((m_run || m_pend) && resteer_valid) begin nr = 2; na = resteer_addr; end
      else if ((m_run || m_pend) && bp_valid) begin nr = 1; na = bp_addr; end
      if (m_pend) begin
        if (fetch_hold) begin
          if (nr > 0 && nr >= m_prank) begin m_paddr = na; m_prank = nr; end
        end else begin
          m_apply((nr > 0 && nr >= m_prank) ? na : m_paddr);
        end
      end else if (nr > 0) begin
        if (fetch_hold) begin
          m_pend = 1'b1; m_run = 1'b0; m_paddr = na; m_prank = nr;
        end else begin
          m_apply(na);
        end
      end else if (m_run && !fetch_hold) begin
        k = 0;
        while (k < N && bank_ld[(m_head + k) % N]) k++;
        for (int b = 0; b < N; b++)
          if (bank_ld[b]) m_line[b] = m_line[b] + LA'(N);
        m_head = (m_head + k) % N;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      for (int b = 0; b < N; b++) chk($sformatf("model line%0d", b), line_of(b), m_line[b]);
      chk("model valid", bank_valid, m_valid);
      chk("model head", head_bank, m_head[0]);
      chk("model epoch", epoch, m_epoch[2:0]);
      chk("model pending", redirect_pending, m_pend);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic iv, input logic [31:0] ia,
                       input logic rv, input logic [31:0] ra,
                       input logic bv, input logic [31:0] ba,
                       input logic h, input logic [1:0] ld);
    @(negedge clk);
    init_valid = iv; init_addr = ia;
    resteer_valid = rv; resteer_addr = ra;
    bp_valid = bv; bp_addr = ba;
    fetch_hold = h; bank_ld = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " bank_line"}, bank_line, '0);
    chk({tag, " valid"}, bank_valid, 2'b00);
    chk({tag, " head"}, head_bank, 1'b0);
    chk({tag, " epoch"}, epoch, 3'd0);
    chk({tag, " pending"}, redirect_pending, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0;
    init_valid = 0; init_addr = 0; resteer_valid = 0; resteer_addr = 0;
    bp_valid = 0; bp_addr = 0; fetch_hold = 0; bank_ld = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Boot
    drive(1, 32'h0000_1010, 0, 0, 0, 0, 0, 2'b00);
    chk("boot bank0", line_of(0), 28'h102);
    chk("boot bank1", line_of(1), 28'h101);
    chk("boot head", head_bank, 1'b1);
    chk("boot valid", bank_valid, 2'b11);
    chk("boot epoch", epoch, 3'd1);

    // Sequencing
    drive(0, 0, 0, 0, 0, 0, 0, 2'b10);
    chk("seq1 bank1", line_of(1), 28'h103);
    chk("seq1 bank0", line_of(0), 28'h102);
    chk("seq1 head", head_bank, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b11);
    chk("seq2 bank0", line_of(0), 28'h104);
    chk("seq2 bank1", line_of(1), 28'h105);
    chk("seq2 head", head_bank, 1'b0);

    // Priority, with bank_ld ignored
    drive(1, 32'h100, 1, 32'h200, 1, 32'h300, 0, 2'b11);
    chk("prio bank0", line_of(0), 28'h10);
    chk("prio bank1", line_of(1), 28'h11);
    chk("prio epoch", epoch, 3'd2);

    // Hold sequence
    drive(0, 0, 0, 0, 1, 32'h2000, 1, 2'b11);
    chk("hold pend", redirect_pending, 1'b1);
    chk("hold frozen", line_of(0), 28'h10);
    drive(0, 0, 1, 32'h3000, 0, 0, 1, 2'b00);
    drive(0, 0, 0, 0, 1, 32'h4000, 1, 2'b00);
    chk("hold epoch", epoch, 3'd2);
    idle_in();
    chk("rel bank0", line_of(0), 28'h300);
    chk("rel bank1", line_of(1), 28'h301);
    chk("rel epoch", epoch, 3'd3);
    chk("rel pend", redirect_pending, 1'b0);

    // Address wrap and epoch wrap
    drive(1, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 2'b00);
    chk("wrap bank1", line_of(1), 28'hFFF_FFFF);
    chk("wrap bank0", line_of(0), 28'h0);
    chk("wrap head", head_bank, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b01);
    chk("wrap ld bank0", line_of(0), 28'h2);
    chk("wrap ld head", head_bank, 1'b1);
    drive(0, 0, 0, 0, 1, 32'h50, 0, 2'b00);
    drive(0, 0, 0, 0, 1, 32'h60, 0, 2'b00);
    drive(0, 0, 0, 0, 1, 32'h70, 0, 2'b00);
    chk("epoch at 7", epoch, 3'd7);
    drive(0, 0, 0, 0, 1, 32'h80, 0, 2'b00);
    chk("epoch wrap", epoch, 3'd0);
    chk("bp bank0", line_of(0), 28'h8);
    chk("bp bank1", line_of(1), 28'h9);

    // Tie in PEND: new wins; lower-priority new loses to stored
    drive(0, 0, 0, 0, 1, 32'h500, 1, 2'b00);
    drive(0, 0, 0, 0, 1, 32'h600, 0, 2'b00);
    chk("tie bank0", line_of(0), 28'h60);
    chk("tie epoch", epoch, 3'd1);
    drive(0, 0, 1, 32'h700, 0, 0, 1, 2'b00);
    drive(0, 0, 0, 0, 1, 32'h800, 0, 2'b00);
    chk("low bank0", line_of(0), 28'h70);
    chk("low bank1", line_of(1), 28'h71);
    chk("low epoch", epoch, 3'd2);

    // Hold in RUN freezes banks
    drive(0, 0, 0, 0, 0, 0, 1, 2'b11);
    chk("freeze bank0", line_of(0), 28'h70);
    chk("freeze pend", redirect_pending, 1'b0);

    // Reset mid-PEND
    drive(0, 0, 0, 0, 1, 32'h900, 1, 2'b00);
    chk("pre-rst pend", redirect_pending, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 1, 32'hA00, 0, 0, 0, 2'b00);
    chk("idle resteer valid", bank_valid, 2'b00);
    chk("idle resteer epoch", epoch, 3'd0);
    drive(1, 32'hB00, 0, 0, 0, 0, 1, 2'b00);
    chk("idle init hold pend", redirect_pending, 1'b1);
    chk("idle init hold valid", bank_valid, 2'b00);
    idle_in();
    chk("init rel bank0", line_of(0), 28'hB0);
    chk("init rel bank1", line_of(1), 28'hB1);
    chk("init rel epoch", epoch, 3'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b01);
    chk("ld01 bank0", line_of(0), 28'hB2);
    chk("ld01 head", head_bank, 1'b1);

    idle_in();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_line_seq.md
FETCH_LINE_SEQ -- requirements
Module: fetch_line_seq

Interface
REQ-001 Parameter NBANKS, default 2: number of line-interleaved I$ banks; power of two, 2..8.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter LINE_BYTES, default 16: line size; power of two. LA_W = ADDR_W - log2(LINE_BYTES).
REQ-004 Parameter EPOCH_W, default 3: redirect epoch counter width.
REQ-005 Clock is one clock, `clk`; reset is asynchronous and active-low, `reset_n`.
REQ-006 Ports, in order:
- `clk` in 1: core clock.
- `reset_n` in 1: async active-low reset.
- `init_valid` in 1, `init_addr` in ADDR_W: boot redirect.
- `resteer_valid` in 1, `resteer_addr` in ADDR_W: writeback resteer.
- `bp_valid` in 1, `bp_addr` in ADDR_W: predicted-taken redirect.
- `fetch_hold` in 1: freeze sequencing.
- `bank_ld` in NBANKS: bank b consumed its current line.
- `bank_line` out NBANKS*LA_W: per-bank line address, bank b at [b*LA_W +: LA_W].
- `bank_valid` out NBANKS: line address of each bank is meaningful.
- `head_bank` out log2(NBANKS): bank holding the oldest unconsumed line.
- `epoch` out EPOCH_W: redirect generation.
- `redirect_pending` out 1: a redirect is captured and not yet applied.

Function
REQ-007 Redirect priority SHALL be init > resteer > bp; only the winner is used.
REQ-008 The state machine SHALL have three states, with these transitions:
- IDLE: only init is honoured; resteer and bp are ignored.
- RUN: normal sequencing.
- PEND: a redirect is stored during hold.
REQ-009 IDLE with init and fetch_hold=0 -> apply the redirect, go to RUN. IDLE with init and fetch_hold=1 -> capture it, go to PEND.
REQ-010 Applying redirect address A SHALL, at the next edge (latency 1), set each bank b:
- `bank_line[b]` = L + ((b - L) mod NBANKS), where L = A >> log2(LINE_BYTES), sum modulo 2^LA_W.
- `bank_valid` = all ones.
- `head_bank` = L mod NBANKS.
- `epoch` += 1, wrapping at 2^EPOCH_W.
REQ-011 RUN, fetch_hold=0, no redirect: each bank with `bank_ld[b]`=1 SHALL advance `bank_line[b]` by NBANKS, modulo 2^LA_W.
REQ-012 `head_bank` SHALL advance by k mod NBANKS, where k = the number of contiguously loaded banks starting at `head_bank` and wrapping.
REQ-013 In RUN, a redirect and `bank_ld` in the same cycle: the redirect SHALL win and `bank_ld` is ignored.
REQ-014 In RUN with fetch_hold=1, bank registers SHALL be frozen and `bank_ld` ignored. A valid redirect in that cycle SHALL be captured, with the state going to PEND.
REQ-015 In PEND, a new redirect whose priority is >= the stored priority SHALL overwrite the stored address and priority; a lower-priority one SHALL be dropped.
REQ-016 PEND with fetch_hold=0: apply per REQ-010 the higher-priority of stored and same-cycle redirects (new wins a tie), clear pending, go to RUN. `epoch` increments exactly once.
REQ-017 `redirect_pending` SHALL be 1 exactly while in PEND.
REQ-018 All outputs SHALL be driven directly from registers, with no combinational input-to-output path.

Reset
REQ-019 Assertion of `reset_n`=0 at any time, including mid-hold or mid-PEND, SHALL immediately reset the block:
- state = IDLE;
- `bank_line` = 0, `bank_valid` = 0, `head_bank` = 0, `epoch` = 0, `redirect_pending` = 0;
- stored redirect cleared.
REQ-020 The first edge after `reset_n` deasserts SHALL behave as IDLE.

Structure
REQ-021 Package `fetch_pkg` SHALL hold:
- the state enum (IDLE/RUN/PEND);
- the redirect-priority encoding (NONE/BP/RESTEER/INIT);
- the line-address width function.
REQ-022 The per-bank register, with load-redirect / increment-by-NBANKS / hold behaviour, SHALL be one sub-module, `fetch_bank_ptr`, instantiated NBANKS times.

Verification (NBANKS=2, ADDR_W=32, LINE_BYTES=16)
REQ-023 Boot: after reset, init 0x0000_1010 -> next cycle:
- bank0=0x102, bank1=0x101;
- head=1, valid=2'b11, epoch=1.
REQ-024 Sequence: `bank_ld`=2'b10 -> bank1=0x103, head=0. Then `bank_ld`=2'b11 -> bank0=0x104, bank1=0x105, head=0.
REQ-025 Priority: simultaneous init 0x100, resteer 0x200, bp 0x300 in RUN -> bank0=0x10, bank1=0x11, epoch+1.
REQ-026 Hold sequence:
- hold=1, bp 0x2000 -> `redirect_pending`=1.
- Then resteer 0x3000 -> stored address becomes 0x3000.
- Then bp 0x4000 -> dropped.
- Then hold=0 -> bank0=0x300, bank1=0x301, epoch+1 once.
REQ-027 Wrap: init 0xFFFF_FFF0 -> bank1=0x0FFF_FFFF, bank0=0x0000_0000, head=1. Then `bank_ld`=2'b01 with epoch at 7 plus a further redirect -> epoch wraps to 0.
REQ-028 Reset mid-PEND: `reset_n`=0 asynchronously -> all outputs 0 before the next edge. Resteer after release -> ignored (IDLE).
